riscv_mc_seq: RTL and testbench

Multicycle sequencer for the RV32I core. It steps one instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared instruction/data memory port using a req/ack handshake. It emits the write-enable and memory-port strobes that sequence the datapath. Mux selects (imm, ALU, rd, PC source) stay in the combinational decoder and are sampled by the datapath when this block pulses the matching enable.

---
 rtl/riscv_mc_seq.sv | 173 +++++++++++++++++
 tb/tb_riscv_mc_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Drives the shared memory port handshake and the datapath write strobes.
module riscv_mc_seq #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TMO_WIDTH   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [6:0]           i_ctrl_opcode,
  input  logic                 i_ctrl_mem_ack,
  output logic                 o_ctrl_mem_req,
  output logic                 o_ctrl_mem_wr_en,
  output logic                 o_ctrl_mem_addr_sel,
  output logic                 o_ctrl_ir_wr_en,
  output logic                 o_ctrl_reg_wr_en,
  output logic                 o_ctrl_pc_wr_en,
  output logic [2:0]           o_ctrl_state,
  output logic [1:0]           o_ctrl_fault,
  output logic [CNT_WIDTH-1:0] o_ctrl_instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] F_ILL = 2'b01;
  localparam logic [1:0] F_TMO = 2'b10;

  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST =
    TMO_WIDTH'(TIMEOUT_CYC - 1);
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [2:0]           state_q, state_d;
  logic [1:0]           fault_q, fault_d;
  logic [TMO_WIDTH-1:0] wait_q, wait_d;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 gap_q, gap_d;

  logic req, wr, asel, irw, regw, pcw;
  logic legal, is_load, is_store, is_branch;
  logic ack, tmo_hit;

  assign ack       = i_ctrl_mem_ack;
  assign is_load   = (i_ctrl_opcode == OP_LOAD);
  assign is_store  = (i_ctrl_opcode == OP_STORE);
  assign is_branch = (i_ctrl_opcode == OP_BRANCH);
  assign tmo_hit   = TMO_EN && (wait_q == TMO_LAST);

  always_comb begin
    legal = 1'b0;
    unique case (i_ctrl_opcode)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111:
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    gap_d   = 1'b0;
    req     = 1'b0;
    wr      = 1'b0;
    asel    = 1'b0;
    irw     = 1'b0;
    regw    = 1'b0;
    pcw     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // gap_q keeps req low for one cycle after a store ack
        req = ~gap_q;
        if (req && ack) begin
          irw     = 1'b1;
          state_d = S_DECODE;
        end else if (req && tmo_hit) begin
          state_d = S_FAULT;
          fault_d = fault_q | F_TMO;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FAULT;
          fault_d = fault_q | F_ILL;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pcw     = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        req  = 1'b1;
        asel = 1'b1;
        wr   = is_store;
        if (ack) begin
          if (is_store) begin
            pcw     = 1'b1;
            gap_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_FAULT;
          fault_d = fault_q | F_TMO;
        end
      end
      S_WB: begin
        regw    = 1'b1;
        pcw     = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
        fault_d = fault_q | F_ILL;
      end
    endcase
  end

  assign wait_d = (req && !ack) ? (wait_q + TMO_ONE) : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_FETCH;
      fault_q   <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      gap_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      if (pcw) begin
        instret_q <= instret_q + CNT_ONE;
      end
    end
  end

  // strobes are forced low while reset is held, without waiting for a clock
  assign o_ctrl_mem_req      = req  & i_rstn;
  assign o_ctrl_mem_wr_en    = wr   & i_rstn;
  assign o_ctrl_mem_addr_sel = asel & i_rstn;
  assign o_ctrl_ir_wr_en     = irw  & i_rstn;
  assign o_ctrl_reg_wr_en    = regw & i_rstn;
  assign o_ctrl_pc_wr_en     = pcw  & i_rstn;
  assign o_ctrl_state        = state_q;
  assign o_ctrl_fault        = fault_q;
  assign o_ctrl_instret      = instret_q;

endmodule

// File: tb/tb_riscv_mc_seq.sv
// Bench for riscv_mc_seq: instruction table with scoreboard,
// plus timeout, illegal-opcode and reset corner sequences.
module tb_riscv_mc_seq;

  logic       clk;
  logic       rstn;
  logic [6:0] opcode;
  logic       ack;
  logic       req, wr_en, asel, ir_wr, reg_wr, pc_wr;
  logic [2:0] state;
  logic [1:0] fault;
  logic [3:0] instret;

  riscv_mc_seq #(
    .CNT_WIDTH  (4),
    .TIMEOUT_CYC(4),
    .TMO_WIDTH  (8)
  ) dut (
    .i_clk              (clk),
    .i_rstn             (rstn),
    .i_ctrl_opcode      (opcode),
    .i_ctrl_mem_ack     (ack),
    .o_ctrl_mem_req     (req),
    .o_ctrl_mem_wr_en   (wr_en),
    .o_ctrl_mem_addr_sel(asel),
    .o_ctrl_ir_wr_en    (ir_wr),
    .o_ctrl_reg_wr_en   (reg_wr),
    .o_ctrl_pc_wr_en    (pc_wr),
    .o_ctrl_state       (state),
    .o_ctrl_fault       (fault),
    .o_ctrl_instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
    string      tr;
    int         regw;
    int         wrc;
  } vec_t;

  typedef struct {
    string tr;
    int    regw;
    int    wrc;
    int    ir;
  } exp_t;

  vec_t vt[11];
  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;
  int   exp_ir;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act,
                      input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s, required %s", name, act, exp);
    end
  endtask

  task automatic push(input string tr, input int regw, input int wrc);
    exp_t e;
    exp_ir = (exp_ir + 1) % 16;
    e.tr   = tr;
    e.regw = regw;
    e.wrc  = wrc;
    e.ir   = exp_ir;
    exp_q.push_back(e);
  endtask

  // Entered at least 1 time unit after a rising edge; returns 1 unit
  // after the edge that retires the instruction.
  task automatic run_instr(input string name, input logic [6:0] op,
                           input int fw, input int mw);
    exp_t  e;
    string tr;
    int    n, regw, wrc, irw, cnt;
    bit    done;
    tr = ""; n = 0; regw = 0; wrc = 0; irw = 0; cnt = 0; done = 0;
    opcode = op;
    while (!done && n < 40) begin
      if (req) ack = (cnt == (asel ? mw : fw));
      else ack = 1'b0;
      #1;
      tr = {tr, $sformatf("%0d", state)};
      n++;
      if (req) cnt = ack ? 0 : cnt + 1;
      else cnt = 0;
      if (reg_wr) regw++;
      if (req && wr_en) wrc++;
      if (ir_wr) irw++;
      if (pc_wr) done = 1;
      @(posedge clk);
      #1;
    end
    ack = 1'b0;
    chk({name, " retired"}, int'(done), 1);
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chks({name, " trace"}, tr, e.tr);
      chk({name, " reg_wr"}, regw, e.regw);
      chk({name, " store cycles"}, wrc, e.wrc);
      chk({name, " ir_wr"}, irw, 1);
      chk({name, " instret"}, int'(instret), e.ir);
    end
  endtask

  initial begin
    int npc, nbad;
    n_chk  = 0;
    n_fail = 0;
    exp_ir = 0;
    rstn   = 1'b0;
    ack    = 1'b1;
    opcode = 7'b0110011;

    // traces are state codes per cycle; after a store, FETCH idles a cycle
    vt[0]  = '{7'b0110011, 0, 0, "0124",        1, 0};
    vt[1]  = '{7'b0000011, 0, 0, "01234",       1, 0};
    vt[2]  = '{7'b0100011, 0, 3, "0123333",     0, 4};
    vt[3]  = '{7'b0010011, 0, 0, "00124",       1, 0};
    vt[4]  = '{7'b1100011, 2, 0, "00012",       0, 0};
    vt[5]  = '{7'b1101111, 0, 0, "0124",        1, 0};
    vt[6]  = '{7'b0110111, 1, 0, "00124",       1, 0};
    vt[7]  = '{7'b0100011, 0, 0, "0123",        0, 1};
    vt[8]  = '{7'b0010111, 0, 0, "00124",       1, 0};
    vt[9]  = '{7'b1100111, 0, 0, "0124",        1, 0};
    vt[10] = '{7'b0000011, 3, 3, "00001233334", 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", int'(state), 0);
    chk("reset req", int'(req), 0);
    chk("reset ir_wr", int'(ir_wr), 0);
    chk("reset fault", int'(fault), 0);
    chk("reset instret", int'(instret), 0);
    ack  = 1'b0;
    rstn = 1'b1;
    #1;

    for (int i = 0; i < 11; i++) begin
      push(vt[i].tr, vt[i].regw, vt[i].wrc);
      run_instr($sformatf("vec%0d", i), vt[i].op, vt[i].fw, vt[i].mw);
    end

    for (int i = 0; i < 17; i++) begin
      push("012", 0, 0);
      run_instr($sformatf("branch%0d", i), 7'b1100011, 0, 0);
    end

    opcode = 7'b0110011;
    ack    = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    chk("tmo not early state", int'(state), 0);
    chk("tmo not early req", int'(req), 1);
    @(posedge clk);
    #1;
    chk("tmo state", int'(state), 5);
    chk("tmo fault", int'(fault), 2);
    chk("tmo req dropped", int'(req), 0);

    #2 rstn = 1'b0;
    #1;
    chk("async rst state", int'(state), 0);
    chk("async rst fault", int'(fault), 0);
    chk("async rst req", int'(req), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ack = 1'b1;
    #1;
    chk("ack at limit ir_wr", int'(ir_wr), 1);
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("ack at limit state", int'(state), 1);
    chk("ack at limit fault", int'(fault), 0);

    opcode = 7'b1111111;
    @(posedge clk);
    #1;
    chk("illegal state", int'(state), 5);
    chk("illegal fault", int'(fault), 1);
    npc  = 0;
    nbad = 0;
    ack  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (pc_wr) npc++;
      if (state != 3'd5 || req) nbad++;
      @(posedge clk);
      #1;
    end
    ack = 1'b0;
    chk("fault pc_wr count", npc, 0);
    chk("fault held cycles off", nbad, 0);
    chk("fault sticky", int'(fault), 1);
    chk("fault instret", int'(instret), 0);

    #2 rstn = 1'b0;
    #1;
    chk("fault rst state", int'(state), 0);
    chk("fault rst fault", int'(fault), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    exp_ir = 0;
    push("0124", 1, 0);
    run_instr("after fault", 7'b0110011, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
